// File: rtl/superh16_icache_refill_ctrl.sv
// I-cache refill controller: one outstanding demand miss, line-aligned L2 read,
// beat assembly into a full line, single-cycle fill strobe and replay/fault pulse.
module superh16_icache_refill_ctrl #(
  parameter int VADDR_WIDTH = 64,
  parameter int LINE_BYTES  = 64,
  parameter int BEAT_BITS   = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_miss_valid,
  input  logic [VADDR_WIDTH-1:0]    i_miss_addr,
  output logic                      o_miss_ready,
  input  logic                      i_flush,
  output logic                      o_l2_req_valid,
  output logic [VADDR_WIDTH-1:0]    o_l2_req_addr,
  input  logic                      i_l2_req_ready,
  input  logic                      i_l2_rsp_valid,
  input  logic [BEAT_BITS-1:0]      i_l2_rsp_data,
  input  logic                      i_l2_rsp_err,
  output logic                      o_fill_valid,
  output logic [VADDR_WIDTH-1:0]    o_fill_addr,
  output logic [LINE_BYTES*8-1:0]   o_fill_data,
  output logic                      o_refill_done,
  output logic                      o_refill_err,
  output logic                      o_busy
);

  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int NBEATS    = LINE_BITS / BEAT_BITS;
  localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0]      LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [VADDR_WIDTH-1:0] LINE_MASK = ~(VADDR_WIDTH'(LINE_BYTES - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [VADDR_WIDTH-1:0]  r_addr;
  logic [BEAT_W-1:0]       r_beat;
  logic                    r_squash;
  logic                    r_err;
  logic [LINE_BITS-1:0]    r_line;
  logic                    w_accept;
  logic                    w_squash;

  // A flush arriving in the FILL cycle itself must still suppress the replay pulse.
  assign w_squash = r_squash | i_flush;
  assign w_accept = i_miss_valid & o_miss_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_miss_ready   = 1'b0;
    o_l2_req_valid = 1'b0;
    o_fill_valid   = 1'b0;
    o_refill_done  = 1'b0;
    o_refill_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_miss_ready = ~i_flush;
        if (i_miss_valid && !i_flush) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        o_l2_req_valid = 1'b1;
        if (i_l2_req_ready) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DATA: begin
        if (i_l2_rsp_valid && (r_beat == LAST_BEAT)) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_FILL: begin
        o_fill_valid  = ~r_err;
        o_refill_done = ~w_squash & ~r_err;
        o_refill_err  = ~w_squash & r_err;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address capture, beat assembly and the sticky squash/error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_beat   <= '0;
      r_squash <= 1'b0;
      r_err    <= 1'b0;
      r_line   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_squash <= 1'b0;
          r_err    <= 1'b0;
          if (w_accept) begin
            r_addr <= i_miss_addr & LINE_MASK;
          end
        end
        S_REQ: begin
          if (i_flush) begin
            r_squash <= 1'b1;
          end
          if (i_l2_req_ready) begin
            r_beat <= '0;
          end
        end
        S_DATA: begin
          if (i_flush) begin
            r_squash <= 1'b1;
          end
          if (i_l2_rsp_valid) begin
            r_line[r_beat*BEAT_BITS +: BEAT_BITS] <= i_l2_rsp_data;
            r_err <= r_err | i_l2_rsp_err;
            if (r_beat == LAST_BEAT) begin
              r_beat <= '0;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        S_FILL: begin
          r_squash <= 1'b0;
          r_err    <= 1'b0;
          r_beat   <= '0;
        end
        default: begin
          r_beat <= '0;
        end
      endcase
    end
  end

  assign o_l2_req_addr = r_addr;
  assign o_fill_addr   = r_addr;
  assign o_fill_data   = r_line;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_superh16_icache_refill_ctrl.sv
// Directed bench for the I-cache refill controller; expected fills are queued
// when the beats are driven and popped in the FILL cycle.
module tb_superh16_icache_refill_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_miss_valid = 1'b0;
  logic [63:0]   i_miss_addr = 64'h0;
  logic          o_miss_ready;
  logic          i_flush = 1'b0;
  logic          o_l2_req_valid;
  logic [63:0]   o_l2_req_addr;
  logic          i_l2_req_ready = 1'b0;
  logic          i_l2_rsp_valid = 1'b0;
  logic [127:0]  i_l2_rsp_data = 128'h0;
  logic          i_l2_rsp_err = 1'b0;
  logic          o_fill_valid;
  logic [63:0]   o_fill_addr;
  logic [511:0]  o_fill_data;
  logic          o_refill_done;
  logic          o_refill_err;
  logic          o_busy;

  superh16_icache_refill_ctrl #(
    .VADDR_WIDTH(64), .LINE_BYTES(64), .BEAT_BITS(128)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_valid(i_miss_valid), .i_miss_addr(i_miss_addr), .o_miss_ready(o_miss_ready),
    .i_flush(i_flush),
    .o_l2_req_valid(o_l2_req_valid), .o_l2_req_addr(o_l2_req_addr), .i_l2_req_ready(i_l2_req_ready),
    .i_l2_rsp_valid(i_l2_rsp_valid), .i_l2_rsp_data(i_l2_rsp_data), .i_l2_rsp_err(i_l2_rsp_err),
    .o_fill_valid(o_fill_valid), .o_fill_addr(o_fill_addr), .o_fill_data(o_fill_data),
    .o_refill_done(o_refill_done), .o_refill_err(o_refill_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  addr;
    logic [511:0] line;
    logic         fv;
    logic         done;
    logic         err;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [63:0]   cur_addr = 64'h0;
  logic [127:0]  bd[4];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_rand_beats();
    for (int k = 0; k < 4; k++) begin
      bd[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  // IDLE cycle presenting the miss, then the first REQ cycle.
  task automatic do_miss(input logic [63:0] a, input logic hold);
    tick();
    i_miss_valid = 1'b1;
    i_miss_addr  = a;
    #1;
    chk1("miss_ready_idle", o_miss_ready, 1'b1);
    chk1("req_valid_in_idle", o_l2_req_valid, 1'b0);
    cur_addr = a & ~64'h3F;
    tick();
    i_miss_valid = hold;
    #1;
    chk1("req_valid_latency", o_l2_req_valid, 1'b1);
    chkw("req_addr_aligned", 512'(o_l2_req_addr), 512'(cur_addr));
    chk1("busy_in_req", o_busy, 1'b1);
    chk1("miss_ready_busy_req", o_miss_ready, 1'b0);
  endtask

  // Stall the request for 'stall' cycles, then handshake; junk beats during REQ must be ignored.
  task automatic req_phase(input int stall, input logic junk);
    i_l2_rsp_valid = junk;
    i_l2_rsp_data  = {128{junk}};
    i_l2_rsp_err   = junk;
    for (int i = 0; i < stall; i++) begin
      chk1("req_valid_stall", o_l2_req_valid, 1'b1);
      chkw("req_addr_stall", 512'(o_l2_req_addr), 512'(cur_addr));
      tick();
      #1;
    end
    i_l2_req_ready = 1'b1;
    #1;
    chk1("req_valid_hs", o_l2_req_valid, 1'b1);
    chkw("req_addr_hs", 512'(o_l2_req_addr), 512'(cur_addr));
    tick();
    i_l2_req_ready = 1'b0;
    i_l2_rsp_valid = 1'b0;
    i_l2_rsp_data  = 128'h0;
    i_l2_rsp_err   = 1'b0;
  endtask

  // Drive bd[0..3]; ends in the FILL cycle after comparing against the scoreboard.
  task automatic beats(input logic [3:0] errm, input int flush_k, input int gap_k);
    exp_t e;
    e.addr = cur_addr;
    for (int k = 0; k < 4; k++) begin
      e.line[k*128 +: 128] = bd[k];
    end
    e.fv   = ~(|errm);
    e.done = (flush_k < 0) && ~(|errm);
    e.err  = (flush_k < 0) && (|errm);
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (k == gap_k) begin
        i_l2_rsp_valid = 1'b0;
        #1;
        chk1("busy_gap", o_busy, 1'b1);
        tick();
      end
      i_l2_rsp_valid = 1'b1;
      i_l2_rsp_data  = bd[k];
      i_l2_rsp_err   = errm[k];
      i_flush        = (k == flush_k);
      #1;
      chk1("fill_valid_early", o_fill_valid, 1'b0);
      chk1("miss_ready_busy_data", o_miss_ready, 1'b0);
      tick();
    end
    i_l2_rsp_valid = 1'b0;
    i_l2_rsp_err   = 1'b0;
    i_flush        = 1'b0;
    #1;
    if (sb.size() == 0) begin
      chk1("scoreboard_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      chk1("fill_valid", o_fill_valid, e.fv);
      chk1("refill_done", o_refill_done, e.done);
      chk1("refill_err", o_refill_err, e.err);
      chkw("fill_addr", 512'(o_fill_addr), 512'(e.addr));
      chkw("fill_data", o_fill_data, e.line);
      chk1("busy_in_fill", o_busy, 1'b1);
      chk1("miss_ready_fill", o_miss_ready, 1'b0);
    end
  endtask

  task automatic idle_chk();
    tick();
    #1;
    chk1("busy_after_fill", o_busy, 1'b0);
    chk1("miss_ready_after_fill", o_miss_ready, 1'b1);
    chk1("fill_valid_once", o_fill_valid, 1'b0);
    chk1("refill_done_once", o_refill_done, 1'b0);
    chk1("refill_err_once", o_refill_err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (2) tick();
    #1;
    chk1("rst_miss_ready", o_miss_ready, 1'b1);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_req_valid", o_l2_req_valid, 1'b0);
    chk1("rst_fill_valid", o_fill_valid, 1'b0);
    chk1("rst_done", o_refill_done, 1'b0);
    chk1("rst_err", o_refill_err, 1'b0);
    chkw("rst_fill_data", o_fill_data, 512'h0);
    chkw("rst_fill_addr", 512'(o_fill_addr), 512'h0);
    tick();
    rst_n = 1'b1;

    // Flush in IDLE has no lasting effect
    tick();
    i_flush = 1'b1;
    #1;
    chk1("miss_ready_flush_idle", o_miss_ready, 1'b0);
    tick();
    i_flush = 1'b0;

    // Test 1: basic refill
    for (int k = 0; k < 4; k++) begin
      bd[k] = {16{8'(8'h11 * (k + 1))}};
    end
    do_miss(64'h0000_0000_8000_0034, 1'b0);
    req_phase(0, 1'b0);
    beats(4'b0000, -1, -1);
    idle_chk();

    // Test 2: request stalled 5 cycles, junk beats in REQ ignored, gap between beats
    set_rand_beats();
    do_miss(64'h1234_5678_9ABC_DEFF, 1'b0);
    req_phase(5, 1'b1);
    beats(4'b0000, -1, 2);
    idle_chk();

    // Test 3: flush during the second beat
    set_rand_beats();
    do_miss(64'h0000_0000_0000_1040, 1'b0);
    req_phase(1, 1'b0);
    beats(4'b0000, 1, -1);
    idle_chk();

    // Test 4: error on the third beat
    set_rand_beats();
    do_miss(64'hFFFF_FFFF_FFFF_FFC1, 1'b0);
    req_phase(0, 1'b0);
    beats(4'b0100, -1, -1);
    idle_chk();

    // Test 5: miss held while busy is re-accepted only once IDLE
    set_rand_beats();
    do_miss(64'h0000_00AB_CDEF_0123, 1'b1);
    req_phase(2, 1'b0);
    beats(4'b0000, -1, -1);
    idle_chk();
    tick();
    i_miss_valid = 1'b0;
    #1;
    chk1("held_miss_reaccepted", o_l2_req_valid, 1'b1);
    chkw("held_miss_addr", 512'(o_l2_req_addr), 512'(cur_addr));
    set_rand_beats();
    req_phase(0, 1'b0);
    beats(4'b0000, -1, -1);
    idle_chk();

    // Miss and flush in the same IDLE cycle: not accepted
    tick();
    i_miss_valid = 1'b1;
    i_miss_addr  = 64'h0000_0000_0000_7777;
    i_flush      = 1'b1;
    #1;
    chk1("miss_flush_ready", o_miss_ready, 1'b0);
    tick();
    i_miss_valid = 1'b0;
    i_flush      = 1'b0;
    #1;
    chk1("miss_flush_busy", o_busy, 1'b0);
    chk1("miss_flush_req", o_l2_req_valid, 1'b0);

    // Test 6: asynchronous reset in DATA, then a normal refill
    set_rand_beats();
    do_miss(64'h0000_0000_0000_2000, 1'b0);
    req_phase(0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      i_l2_rsp_valid = 1'b1;
      i_l2_rsp_data  = bd[k];
      tick();
    end
    i_l2_rsp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_busy", o_busy, 1'b0);
    chk1("arst_miss_ready", o_miss_ready, 1'b1);
    chk1("arst_req_valid", o_l2_req_valid, 1'b0);
    chk1("arst_fill_valid", o_fill_valid, 1'b0);
    chkw("arst_fill_data", o_fill_data, 512'h0);
    chkw("arst_fill_addr", 512'(o_fill_addr), 512'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    set_rand_beats();
    do_miss(64'h0000_0000_0000_3FC8, 1'b0);
    req_phase(3, 1'b0);
    beats(4'b0000, -1, -1);
    idle_chk();

    chk1("scoreboard_drained", (sb.size() == 0), 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
